// File: rtl/timer_pkg.sv
// Shared types for the reload down timer: FSM states, count modes, default prescale ratio.
// Optional prescaler is controlled by TIMER_PRESCALE_EN (see reload_down_timer).
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  typedef enum logic {
    ONE_SHOT    = 1'b0,
    AUTO_RELOAD = 1'b1
  } timer_mode_t;

  localparam int PRESC_DIV_DEFAULT = 4;

endpackage

// File: rtl/reload_down_timer_tick_prescaler.sv
// Divides an enable stream by DIV: tick is combinational, high on every DIV-th enabled cycle.
// clr restarts the division phase; used only when TIMER_PRESCALE_EN is defined.
module tick_prescaler #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/reload_down_timer.sv
// Loadable down timer with start/stop, one-shot/auto-reload and a registered tc pulse.
// Define TIMER_PRESCALE_EN to step the count once per PRESC_DIV enabled cycles.
module reload_down_timer
  import timer_pkg::*;
#(
  parameter int WIDTH     = 5,
  parameter int PRESC_DIV = PRESC_DIV_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  timer_state_t     state_q, state_d;
  timer_mode_t      mode_q, mode_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             tick;

`ifdef TIMER_PRESCALE_EN
  tick_prescaler #(
    .DIV (PRESC_DIV)
  ) u_presc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (load | stop | start),
    .en    (en && (state_q == RUN)),
    .tick  (tick)
  );
`else
  assign tick = en;
`endif

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;

    if (load) begin
      count_d  = data;
      reload_d = data;
      mode_d   = timer_mode_t'(mode);
      state_d  = IDLE;
    end else if (stop && (state_q == RUN)) begin
      state_d = IDLE;
    end else if (start && (state_q != RUN)) begin
      if (state_q == DONE) begin
        // Restart from the reload value; a zero reload just re-signals completion.
        if (reload_q != '0) begin
          count_d = reload_q;
          state_d = RUN;
        end else begin
          tc_d = 1'b1;
        end
      end else if (count_q != '0) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        tc_d    = 1'b1;
      end
    end else if (tick && (state_q == RUN)) begin
      if (count_q == CNT_ONE) begin
        tc_d = 1'b1;
        if (mode_q == AUTO_RELOAD) begin
          count_d = reload_q;
        end else begin
          count_d = '0;
          state_d = DONE;
        end
      end else if (count_q != '0) begin
        count_d = count_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mode_q   <= ONE_SHOT;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);

endmodule

// File: tb/tb_reload_down_timer.sv
// Directed scoreboard bench for reload_down_timer: per-cycle expected outputs are queued by the
// stimulus and checked by an independent monitor after each rising edge.
module tb_reload_down_timer;

  logic       clk = 1'b0;
  logic       rst_n, load, mode, start, stop, en;
  logic [4:0] data;
  logic [4:0] count;
  logic       tc, busy, done;

  always #5 clk = ~clk;

  reload_down_timer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .data  (data),
    .mode  (mode),
    .start (start),
    .stop  (stop),
    .en    (en),
    .count (count),
    .tc    (tc),
    .busy  (busy),
    .done  (done)
  );

  typedef struct packed {
    logic [4:0] count;
    logic       tc;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t exp_q[$];
  int   id_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   n_step = 0;
  exp_t mon_x;
  int   mon_id;

  task automatic step(input logic rn, input logic ld, input logic [4:0] d, input logic m,
                      input logic st, input logic sp, input logic e,
                      input logic [4:0] ec, input logic et, input logic eb, input logic ed);
    exp_t x;
    @(negedge clk);
    rst_n = rn; load = ld; data = d; mode = m; start = st; stop = sp; en = e;
    x.count = ec; x.tc = et; x.busy = eb; x.done = ed;
    exp_q.push_back(x);
    id_q.push_back(n_step);
    n_step++;
  endtask

  task automatic tk(input logic e, input logic [4:0] ec, input logic et, input logic eb, input logic ed);
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, e, ec, et, eb, ed);
  endtask

  task automatic ld(input logic [4:0] d, input logic m);
    step(1'b1, 1'b1, d, m, 1'b0, 1'b0, 1'b1, d, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic st(input logic [4:0] ec, input logic et, input logic eb, input logic ed);
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, ec, et, eb, ed);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_x  = exp_q.pop_front();
      mon_id = id_q.pop_front();
      n_cmp++;
      if ({count, tc, busy, done} !== mon_x) begin
        n_fail++;
        $display("FAIL step%0d: got count=%0d tc=%b busy=%b done=%b, want count=%0d tc=%b busy=%b done=%b",
                 mon_id, count, tc, busy, done, mon_x.count, mon_x.tc, mon_x.busy, mon_x.done);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; load = 1'b0; data = 5'd0; mode = 1'b0; start = 1'b0; stop = 1'b0; en = 1'b0;
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef TIMER_PRESCALE_EN
    // Prescale 4: load 2 -> tc after 8 enabled cycles.
    ld(5'd2, 1'b0);
    st(5'd2, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      tk(1'b1, (k < 4) ? 5'd2 : ((k < 8) ? 5'd1 : 5'd0), k == 8, k != 8, k == 8);
    end
    // Three disabled cycles delay tc by exactly three cycles.
    ld(5'd2, 1'b0);
    st(5'd2, 1'b0, 1'b1, 1'b0);
    begin
      int k;
      k = 0;
      for (int c = 1; c <= 11; c++) begin
        logic e;
        e = !(c >= 3 && c <= 5);
        if (e) k++;
        tk(e, (k < 4) ? 5'd2 : ((k < 8) ? 5'd1 : 5'd0), e && (k == 8), k != 8, k == 8);
      end
    end
    tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
`else
    // One-shot from 3.
    ld(5'd3, 1'b0);
    st(5'd3, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd2, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
    tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);

    // Auto-reload 4; a start while running is ignored.
    ld(5'd4, 1'b1);
    st(5'd4, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, 5'd0, 1'b0, i == 6, 1'b0, 1'b1,
           (i % 4 == 0) ? 5'd4 : 5'(4 - (i % 4)), i % 4 == 0, 1'b1, 1'b0);
    end
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);

    // Pause / resume, then load+stop together.
    ld(5'd20, 1'b0);
    st(5'd20, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 5; i++) tk(1'b1, 5'(20 - i), 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    tk(1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    tk(1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    st(5'd15, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd14, 1'b0, 1'b1, 1'b0);
    tk(1'b0, 5'd14, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    tk(1'b1, 5'd9, 1'b0, 1'b0, 1'b0);

    // Zero load: start goes straight to DONE with one tc, and again from DONE.
    ld(5'd0, 1'b0);
    st(5'd0, 1'b1, 1'b0, 1'b1);
    tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    st(5'd0, 1'b1, 1'b0, 1'b1);
    tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);

    // Full-scale one-shot, no wrap after zero, restart from DONE.
    ld(5'd31, 1'b0);
    st(5'd31, 1'b0, 1'b1, 1'b0);
    for (int i = 1; i <= 31; i++) tk(1'b1, 5'(31 - i), i == 31, i != 31, i == 31);
    tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
    st(5'd31, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd30, 1'b0, 1'b1, 1'b0);

    // Reset while running at 7; no tc afterwards.
    for (int i = 1; i <= 23; i++) tk(1'b1, 5'(30 - i), 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 10; i++) tk(1'b1, 5'd0, 1'b0, 1'b0, 1'b0);

    // Load on the terminal cycle suppresses tc.
    ld(5'd2, 1'b1);
    st(5'd2, 1'b0, 1'b1, 1'b0);
    tk(1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    tk(1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
`endif

    w = 0;
    while (exp_q.size() > 0 && w < 20) begin
      @(posedge clk);
      w++;
    end
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/reload_down_timer.md
Name: reload_down_timer

Overview:
Parametrised successor to the team's 5-bit loadable down counter. Adds the following:
- start/stop control
- one-shot and auto-reload modes
- a registered terminal-count pulse
- status flags
It sits beside control FSMs as a generic event/delay timer. It counts down one step per tick, where a tick is `en`, optionally divided by a prescaler.

Parameters:
- WIDTH, 5: width of `data`, `count` and the reload register.
- PRESC_DIV, 4: prescaler ratio, minimum 2. Used only when TIMER_PRESCALE_EN is defined.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: synchronous active-low reset.
- load, input, 1: capture `data` and `mode`; highest priority.
- data, input, WIDTH: load/reload value.
- mode, input, 1: 0 = one-shot, 1 = auto-reload. Sampled only with `load`.
- start, input, 1: begin, resume or restart counting.
- stop, input, 1: pause counting (RUN -> IDLE).
- en, input, 1: count enable; each tick is qualified by `en`.
- count, output, WIDTH: current count value.
- tc, output, 1: one-cycle terminal-count pulse, registered.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - count=0, reload_q=0, mode_q=0, state=IDLE.
  - tc=0, busy=0, done=0, prescaler counter=0.
  - Reset mid-count aborts immediately; no tc is produced.
- States: IDLE, RUN, DONE. `busy` and `done` are decoded from registered state, so there is no combinational path from the inputs.
- Priority per cycle: `load` > `stop` > `start` > tick.
- load (any state): count<=data, reload_q<=data, mode_q<=mode, state<=IDLE, tc<=0.
- stop:
  - In RUN: state<=IDLE, count is held.
  - In IDLE or DONE: no effect.
- start in IDLE:
  - If count!=0: state<=RUN. Counting resumes from the held count.
  - If count==0: state<=DONE, tc<=1 on the next cycle.
- start in DONE:
  - If reload_q!=0: count<=reload_q, state<=RUN (restart).
  - Otherwise: stays DONE and pulses tc again.
- start in RUN: ignored.
- Tick in RUN with count>1: count<=count-1.
- Tick in RUN with count==1:
  - One-shot (mode_q=0): count<=0, tc<=1, state<=DONE.
  - Auto-reload (mode_q=1): count<=reload_q, tc<=1, state stays RUN.
- Period:
  - Auto-reload period = reload_q ticks; tc spacing equals reload_q ticks.
  - One-shot: tc is asserted reload_q ticks after start.
- Ticks outside RUN, or with en=0: count is held.
- Arithmetic: unsigned WIDTH bits.
  - Decrement never wraps: the count==1 branch always preempts 0 -> all-ones.
  - The maximum load value is 2^WIDTH-1.
- tc is asserted for exactly one clk cycle per terminal event.
  - tc is never asserted in the same cycle as reset.
  - tc is never asserted in the cycle after a load.

Optional Feature:
TIMER_PRESCALE_EN
- Defined:
  - An internal counter of width $clog2(PRESC_DIV) increments on each clk with en=1 while in RUN.
  - tick = en && presc_cnt==PRESC_DIV-1; presc_cnt wraps to 0 on that cycle.
  - presc_cnt is cleared on reset, load, stop and start.
  - One count step therefore takes PRESC_DIV enabled cycles.
- Not defined: tick = en. PRESC_DIV is unused and no prescaler logic is generated.

Decomposition:
- Package timer_pkg contains:
  - typedef enum logic [1:0] timer_state_t {IDLE, RUN, DONE}
  - typedef enum logic timer_mode_t {ONE_SHOT=1'b0, AUTO_RELOAD=1'b1}
  - localparam PRESC_DIV_DEFAULT=4
- Natural sub-module: tick_prescaler, with ports clk, rst_n, clr, en, tick and parameter DIV.
  - Instantiated only under TIMER_PRESCALE_EN; otherwise a plain assign.
- Main module: the FSM plus the count/reload datapath.

Test Plan:
1. One-shot: load data=3, mode=0; start; en=1 constant.
   - Expect count 3,2,1,0 on successive cycles.
   - Expect tc high for exactly one cycle as count becomes 0, then done=1, busy=0.
2. Auto-reload: load data=4, mode=1; start; en=1 for 12 cycles.
   - Expect count 4,3,2,1,4,3,2,1,...
   - Expect tc every 4th cycle, busy stays 1, done=0.
3. Pause/resume: WIDTH=5, load 20, start; after 5 ticks assert stop.
   - Expect count held at 15 in IDLE with en=1.
   - start again -> 14 next tick.
   - Simultaneous load=1 and stop=1 with data=9 -> count=9, state IDLE.
4. Boundary:
   - load 0, start -> done=1 and a single tc pulse, count stays 0.
   - load 31, run one-shot -> exactly 31 ticks to tc, no wrap to 31 after 0.
   - start in DONE after load 31 restarts at 31.
5. Reset mid-operation: rst_n=0 for one edge while count=7 in RUN.
   - Expect count=0, IDLE, busy=0, tc=0; no tc in the following 10 cycles.
6. With TIMER_PRESCALE_EN and PRESC_DIV=4: load 2, start, en=1.
   - Expect tc exactly 8 enabled cycles after start.
   - Toggling en=0 for 3 cycles delays tc by exactly 3 cycles.
